aurora_link_ctrl: RTL and testbench

Bring-up and recovery sequencer for the 2-lane Aurora link that carries the AXI Chip2Chip master.
- Drives Aurora pma_init/reset_pb in the required order and waits for channel/lane up.
- Releases the C2C reset only after the link has been stable for a set time, and retries on timeout or link loss.
- Provides status counters and drives the 4 board LEDs.

---
 rtl/aurora_link_pkg.sv | 26 ++
 rtl/aurora_link_ctrl_sync.sv | 23 ++
 rtl/aurora_link_ctrl.sv | 152 +++++++++++++++
 tb/tb_aurora_link_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_link_pkg.sv
// Shared types and constants for the Aurora/C2C link bring-up sequencer.
package aurora_link_pkg;

  localparam int CNT_W   = 8;
  localparam int TIMER_W = 24;

  localparam int LED_LINK  = 0;
  localparam int LED_HB    = 1;
  localparam int LED_TRAIN = 2;
  localparam int LED_FAIL  = 3;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PMA    = 3'd1,
    ST_RST    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STABLE = 3'd4,
    ST_UP     = 3'd5,
    ST_FAIL   = 3'd6
  } link_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/aurora_link_ctrl_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_link_ctrl.sv
// Aurora pma_init/reset_pb bring-up and recovery sequencer gating the C2C master reset.
module aurora_link_ctrl
  import aurora_link_pkg::*;
#(
  parameter int unsigned PMA_INIT_CYCLES   = 1024,
  parameter int unsigned RESET_CYCLES      = 128,
  parameter int unsigned UP_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned STABLE_CYCLES     = 256,
  parameter int unsigned MAX_RETRIES       = 15,
  parameter int          HB_DIV_LOG2       = 26
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start_en,
  input  logic       force_retrain,
  input  logic       channel_up,
  input  logic [1:0] lane_up,
  input  logic       c2c_link_error,
  output logic       aurora_pma_init,
  output logic       aurora_reset_pb,
  output logic       c2c_aresetn,
  output logic       link_ok,
  output logic [7:0] retry_cnt,
  output logic [7:0] drop_cnt,
  output logic [2:0] fsm_state,
  output logic       failed,
  output logic [3:0] led_out
);

  localparam logic [TIMER_W-1:0] PMA_LAST    = TIMER_W'(PMA_INIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] UP_LAST     = TIMER_W'(UP_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);

  logic [3:0]           sync_q;
  logic                 link_s;
  logic                 err_s;
  link_state_t          state_q, state_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [CNT_W-1:0]     retry_q, retry_d, retry_inc;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic                 restart;
  logic                 enter;
  logic                 train_q;
  logic [HB_DIV_LOG2:0] hb_cnt;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (aclk),
    .rst_n (aresetn),
    .d     ({c2c_link_error, lane_up, channel_up}),
    .q     (sync_q)
  );

  assign link_s = sync_q[0] & sync_q[1] & sync_q[2];
  assign err_s  = sync_q[3];

  // A retrain while already in PMA re-enters the state, so the timer must restart too.
  assign restart = start_en && force_retrain && (state_q != ST_OFF);
  assign enter   = restart || (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    drop_d    = drop_q;
    retry_inc = sat_inc(retry_q);
    if (!start_en) begin
      state_d = ST_OFF;
    end else if (restart) begin
      state_d = ST_PMA;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_PMA;
        ST_PMA:  if (timer_q == PMA_LAST) state_d = ST_RST;
        ST_RST:  if (timer_q == RST_LAST) state_d = ST_WAIT;
        ST_WAIT: begin
          if (link_s) begin
            state_d = ST_STABLE;
          end else if (timer_q == UP_LAST) begin
            retry_d = retry_inc;
            if (MAX_RETRIES != 0 && 32'(retry_inc) >= MAX_RETRIES) state_d = ST_FAIL;
            else state_d = ST_PMA;
          end
        end
        ST_STABLE: begin
          if (!link_s) begin
            state_d = ST_WAIT;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_UP;
            retry_d = '0;
          end
        end
        ST_UP: begin
          if (!link_s || err_s) begin
            state_d = ST_RST;
            drop_d  = sat_inc(drop_q);
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_OFF;
      timer_q <= '0;
      retry_q <= '0;
      drop_q  <= '0;
      hb_cnt  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= enter ? '0 : timer_q + 1'b1;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      hb_cnt  <= hb_cnt + 1'b1;
    end
  end

  // Outputs decode the next state so they change on the same edge as state_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aurora_pma_init <= 1'b1;
      aurora_reset_pb <= 1'b1;
      c2c_aresetn     <= 1'b0;
      link_ok         <= 1'b0;
      failed          <= 1'b0;
      train_q         <= 1'b0;
    end else begin
      aurora_pma_init <= state_d inside {ST_OFF, ST_PMA, ST_FAIL};
      aurora_reset_pb <= state_d inside {ST_OFF, ST_PMA, ST_RST, ST_FAIL};
      c2c_aresetn     <= (state_d == ST_UP);
      link_ok         <= (state_d == ST_UP);
      failed          <= (state_d == ST_FAIL);
      train_q         <= state_d inside {ST_WAIT, ST_STABLE};
    end
  end

  always_comb begin
    led_out            = '0;
    led_out[LED_LINK]  = link_ok;
    led_out[LED_HB]    = hb_cnt[HB_DIV_LOG2];
    led_out[LED_TRAIN] = train_q;
    led_out[LED_FAIL]  = failed;
  end

  assign fsm_state = state_q;
  assign retry_cnt = retry_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// Directed bench for aurora_link_ctrl with short dwell times and hand-computed timelines.
module tb_aurora_link_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       start_en;
  logic       force_retrain;
  logic       channel_up;
  logic [1:0] lane_up;
  logic       c2c_link_error;
  logic       aurora_pma_init;
  logic       aurora_reset_pb;
  logic       c2c_aresetn;
  logic       link_ok;
  logic [7:0] retry_cnt;
  logic [7:0] drop_cnt;
  logic [2:0] fsm_state;
  logic       failed;
  logic [3:0] led_out;

  int vectors = 0;
  int miscompares = 0;

  aurora_link_ctrl #(
    .PMA_INIT_CYCLES   (4),
    .RESET_CYCLES      (2),
    .UP_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES     (3),
    .MAX_RETRIES       (3),
    .HB_DIV_LOG2       (4)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start_en        (start_en),
    .force_retrain   (force_retrain),
    .channel_up      (channel_up),
    .lane_up         (lane_up),
    .c2c_link_error  (c2c_link_error),
    .aurora_pma_init (aurora_pma_init),
    .aurora_reset_pb (aurora_reset_pb),
    .c2c_aresetn     (c2c_aresetn),
    .link_ok         (link_ok),
    .retry_cnt       (retry_cnt),
    .drop_cnt        (drop_cnt),
    .fsm_state       (fsm_state),
    .failed          (failed),
    .led_out         (led_out)
  );

  always #5 aclk = ~aclk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; start_en = 1'b0; force_retrain = 1'b0;
    channel_up = 1'b1; lane_up = 2'b11; c2c_link_error = 1'b0;
    step(3);
    vectors++; if (fsm_state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
    vectors++; if ({aurora_pma_init, aurora_reset_pb, c2c_aresetn, link_ok, failed} !== 5'b11000) begin
      miscompares++; $display("FAIL rst_ctl: got %b want 11000", {aurora_pma_init, aurora_reset_pb, c2c_aresetn, link_ok, failed}); end
    vectors++; if ({retry_cnt, drop_cnt, led_out} !== 20'd0) begin
      miscompares++; $display("FAIL rst_cnt_led: got retry %0d drop %0d led %b want 0", retry_cnt, drop_cnt, led_out); end
    aresetn = 1'b1;
  endtask

  task automatic test_heartbeat;
    step(15);
    vectors++; if (led_out !== 4'b0000) begin miscompares++; $display("FAIL hb_low: got %b want 0000", led_out); end
    step(1);
    vectors++; if (led_out !== 4'b0010) begin miscompares++; $display("FAIL hb_high: got %b want 0010", led_out); end
  endtask

  task automatic test_bring_up;
    start_en = 1'b1;
    step(1);
    vectors++; if (fsm_state !== 3'd1 || aurora_pma_init !== 1'b1) begin
      miscompares++; $display("FAIL bu_pma: got state %0d pma %b want 1 1", fsm_state, aurora_pma_init); end
    step(3);
    vectors++; if (fsm_state !== 3'd1 || aurora_pma_init !== 1'b1) begin
      miscompares++; $display("FAIL bu_pma_last: got state %0d pma %b want 1 1", fsm_state, aurora_pma_init); end
    step(1);
    vectors++; if (fsm_state !== 3'd2 || aurora_pma_init !== 1'b0 || aurora_reset_pb !== 1'b1) begin
      miscompares++; $display("FAIL bu_rst: got state %0d pma %b rpb %b want 2 0 1", fsm_state, aurora_pma_init, aurora_reset_pb); end
    step(1);
    vectors++; if (fsm_state !== 3'd2 || aurora_reset_pb !== 1'b1) begin
      miscompares++; $display("FAIL bu_rst_last: got state %0d rpb %b want 2 1", fsm_state, aurora_reset_pb); end
    step(1);
    vectors++; if (fsm_state !== 3'd3 || aurora_reset_pb !== 1'b0 || led_out[2] !== 1'b1) begin
      miscompares++; $display("FAIL bu_wait: got state %0d rpb %b led2 %b want 3 0 1", fsm_state, aurora_reset_pb, led_out[2]); end
    step(3);
    vectors++; if (fsm_state !== 3'd4 || c2c_aresetn !== 1'b0) begin
      miscompares++; $display("FAIL bu_stable_end: got state %0d c2c %b want 4 0", fsm_state, c2c_aresetn); end
    step(1);
    vectors++; if (fsm_state !== 3'd5 || c2c_aresetn !== 1'b1 || link_ok !== 1'b1 || retry_cnt !== 8'd0) begin
      miscompares++; $display("FAIL bu_up: got state %0d c2c %b ok %b retry %0d want 5 1 1 0", fsm_state, c2c_aresetn, link_ok, retry_cnt); end
    vectors++; if ((led_out & 4'b1101) !== 4'b0001) begin
      miscompares++; $display("FAIL bu_led: got %b want x0x1 pattern 0001 (hb masked)", led_out); end
  endtask

  task automatic test_drop_in_up;
    channel_up = 1'b0;
    step(1);
    channel_up = 1'b1;
    step(1);
    vectors++; if (fsm_state !== 3'd5 || c2c_aresetn !== 1'b1) begin
      miscompares++; $display("FAIL drop_pre: got state %0d c2c %b want 5 1", fsm_state, c2c_aresetn); end
    step(1);
    vectors++; if (fsm_state !== 3'd2 || c2c_aresetn !== 1'b0 || drop_cnt !== 8'd1 || aurora_pma_init !== 1'b0) begin
      miscompares++; $display("FAIL drop_rst: got state %0d c2c %b drop %0d pma %b want 2 0 1 0", fsm_state, c2c_aresetn, drop_cnt, aurora_pma_init); end
    step(2);
    vectors++; if (fsm_state !== 3'd3) begin miscompares++; $display("FAIL drop_wait: got %0d want 3", fsm_state); end
    step(4);
    vectors++; if (fsm_state !== 3'd5 || c2c_aresetn !== 1'b1 || drop_cnt !== 8'd1) begin
      miscompares++; $display("FAIL drop_relink: got state %0d c2c %b drop %0d want 5 1 1", fsm_state, c2c_aresetn, drop_cnt); end
  endtask

  task automatic test_stable_glitch;
    start_en = 1'b0;
    step(1);
    vectors++; if (fsm_state !== 3'd0 || aurora_pma_init !== 1'b1 || aurora_reset_pb !== 1'b1 || c2c_aresetn !== 1'b0 || drop_cnt !== 8'd1) begin
      miscompares++; $display("FAIL gl_off: got state %0d pma %b rpb %b c2c %b drop %0d want 0 1 1 0 1",
        fsm_state, aurora_pma_init, aurora_reset_pb, c2c_aresetn, drop_cnt); end
    start_en = 1'b1;
    step(6);
    channel_up = 1'b0;
    step(1);
    channel_up = 1'b1;
    vectors++; if (fsm_state !== 3'd3) begin miscompares++; $display("FAIL gl_wait: got %0d want 3", fsm_state); end
    step(1);
    vectors++; if (fsm_state !== 3'd4) begin miscompares++; $display("FAIL gl_stable: got %0d want 4", fsm_state); end
    step(1);
    vectors++; if (fsm_state !== 3'd3 || c2c_aresetn !== 1'b0) begin
      miscompares++; $display("FAIL gl_back_wait: got state %0d c2c %b want 3 0", fsm_state, c2c_aresetn); end
    step(3);
    vectors++; if (fsm_state !== 3'd4 || c2c_aresetn !== 1'b0) begin
      miscompares++; $display("FAIL gl_window: got state %0d c2c %b want 4 0", fsm_state, c2c_aresetn); end
    step(1);
    vectors++; if (fsm_state !== 3'd5 || c2c_aresetn !== 1'b1) begin
      miscompares++; $display("FAIL gl_up: got state %0d c2c %b want 5 1", fsm_state, c2c_aresetn); end
  endtask

  task automatic test_simultaneous;
    c2c_link_error = 1'b1;
    step(2);
    vectors++; if (fsm_state !== 3'd5) begin miscompares++; $display("FAIL sim_pre: got %0d want 5", fsm_state); end
    start_en = 1'b0;
    step(1);
    vectors++; if (fsm_state !== 3'd0 || drop_cnt !== 8'd1 || aurora_pma_init !== 1'b1 || c2c_aresetn !== 1'b0 || link_ok !== 1'b0) begin
      miscompares++; $display("FAIL sim_off: got state %0d drop %0d pma %b c2c %b ok %b want 0 1 1 0 0",
        fsm_state, drop_cnt, aurora_pma_init, c2c_aresetn, link_ok); end
    c2c_link_error = 1'b0;
  endtask

  task automatic test_timeout_retry;
    channel_up = 1'b0;
    step(3);
    start_en = 1'b1;
    step(7);
    vectors++; if (fsm_state !== 3'd3 || led_out[2] !== 1'b1) begin
      miscompares++; $display("FAIL to_wait: got state %0d led2 %b want 3 1", fsm_state, led_out[2]); end
    step(19);
    vectors++; if (fsm_state !== 3'd3 || retry_cnt !== 8'd0) begin
      miscompares++; $display("FAIL to_wait_last: got state %0d retry %0d want 3 0", fsm_state, retry_cnt); end
    step(1);
    vectors++; if (fsm_state !== 3'd1 || retry_cnt !== 8'd1) begin
      miscompares++; $display("FAIL to_retry1: got state %0d retry %0d want 1 1", fsm_state, retry_cnt); end
    step(25);
    vectors++; if (fsm_state !== 3'd3 || retry_cnt !== 8'd1) begin
      miscompares++; $display("FAIL to_wait2_last: got state %0d retry %0d want 3 1", fsm_state, retry_cnt); end
    step(1);
    vectors++; if (fsm_state !== 3'd1 || retry_cnt !== 8'd2) begin
      miscompares++; $display("FAIL to_retry2: got state %0d retry %0d want 1 2", fsm_state, retry_cnt); end
    step(26);
    vectors++; if (fsm_state !== 3'd6 || retry_cnt !== 8'd3 || failed !== 1'b1 || led_out[3] !== 1'b1) begin
      miscompares++; $display("FAIL to_fail: got state %0d retry %0d failed %b led3 %b want 6 3 1 1", fsm_state, retry_cnt, failed, led_out[3]); end
    vectors++; if (aurora_pma_init !== 1'b1 || aurora_reset_pb !== 1'b1 || drop_cnt !== 8'd1 || led_out[2] !== 1'b0) begin
      miscompares++; $display("FAIL to_fail_ctl: got pma %b rpb %b drop %0d led2 %b want 1 1 1 0", aurora_pma_init, aurora_reset_pb, drop_cnt, led_out[2]); end
    step(5);
    vectors++; if (fsm_state !== 3'd6) begin miscompares++; $display("FAIL to_fail_hold: got %0d want 6", fsm_state); end
    force_retrain = 1'b1;
    step(1);
    force_retrain = 1'b0;
    vectors++; if (fsm_state !== 3'd1 || retry_cnt !== 8'd0 || failed !== 1'b0) begin
      miscompares++; $display("FAIL to_retrain: got state %0d retry %0d failed %b want 1 0 0", fsm_state, retry_cnt, failed); end
  endtask

  task automatic test_reset_mid;
    step(6);
    vectors++; if (fsm_state !== 3'd3) begin miscompares++; $display("FAIL rm_wait: got %0d want 3", fsm_state); end
    step(2);
    aresetn = 1'b0;
    #2;
    vectors++; if (fsm_state !== 3'd0 || {aurora_pma_init, aurora_reset_pb, c2c_aresetn, link_ok, failed} !== 5'b11000) begin
      miscompares++; $display("FAIL rm_async: got state %0d ctl %b want 0 11000", fsm_state, {aurora_pma_init, aurora_reset_pb, c2c_aresetn, link_ok, failed}); end
    vectors++; if ({retry_cnt, drop_cnt, led_out} !== 20'd0) begin
      miscompares++; $display("FAIL rm_cnt_led: got retry %0d drop %0d led %b want 0", retry_cnt, drop_cnt, led_out); end
    channel_up = 1'b1;
    step(1);
    #2;
    aresetn = 1'b1;
    step(1);
    vectors++; if (fsm_state !== 3'd1 || aurora_pma_init !== 1'b1) begin
      miscompares++; $display("FAIL rm_pma: got state %0d pma %b want 1 1", fsm_state, aurora_pma_init); end
    step(6);
    vectors++; if (fsm_state !== 3'd3) begin miscompares++; $display("FAIL rm_wait2: got %0d want 3", fsm_state); end
    step(4);
    vectors++; if (fsm_state !== 3'd5 || c2c_aresetn !== 1'b1 || drop_cnt !== 8'd0) begin
      miscompares++; $display("FAIL rm_up: got state %0d c2c %b drop %0d want 5 1 0", fsm_state, c2c_aresetn, drop_cnt); end
  endtask

  initial begin
    test_reset;
    test_heartbeat;
    test_bring_up;
    test_drop_in_up;
    test_stable_glitch;
    test_simultaneous;
    test_timeout_retry;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
